// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA decrypt engine.
// Holds the control state encoding and the operation/reduction length helpers.
package rsa_pkg;

    typedef enum logic [2:0] {IDLE, PRE, SQ, ML, NEXT, DONE} state_t;

    // One modular operation: a multiply cycle followed by one reduction cycle per product bit.
    function automatic int op_len(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int red_cnt_w(input int w);
        return $clog2(op_len(w));
    endfunction

    function automatic int msb_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/rsa_decrypt_engine_mod_reduce_seq.sv
// Restoring shift-subtract reducer: rem = prod mod N, one product bit per cycle, MSB first.
// Loads on start, then runs 2n cycles; done and rem are valid together in the final cycle.
module mod_reduce_seq import rsa_pkg::*; #(
    parameter int n = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*n-1:0] prod,
    input  logic [n-1:0]   N,
    output logic [n-1:0]   rem,
    output logic           done
);

    localparam int CW = red_cnt_w(n);

    logic [2*n-1:0] sh_q;
    logic [n:0]     rem_q;
    logic [n:0]     trial;
    logic [n:0]     rem_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;

    // rem_q is always < N < 2^n, so dropping its top bit before the shift loses nothing.
    always_comb begin
        trial = {rem_q[n-1:0], sh_q[2*n-1]};
        rem_d = (trial >= {1'b0, N}) ? (trial - {1'b0, N}) : trial;
    end

    assign rem  = rem_d[n-1:0];
    assign done = busy_q && (cnt_q == CW'(2 * n - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            sh_q   <= prod;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sh_q   <= sh_q << 1;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + CW'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_decrypt_engine.sv
// RSA decrypt engine: M = C^D mod N by left-to-right square-and-multiply over a sequential reducer.
// Optional RSA_EARLY_SKIP_EN starts squaring at the MSB set in D (and skips straight to DONE for D=0).
module rsa_decrypt_engine import rsa_pkg::*; #(
    parameter int n = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] CIPHER,
    input  logic [n-1:0] PRIV_KEY,
    input  logic [n-1:0] N,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] RESULT,
    output logic         err
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;

    state_t         state_q;
    logic [n-1:0]   c_q, d_q, n_q, acc_q, result_q;
    logic [IW-1:0]  i_q;
    logic           mul_q, in_ready_q, out_valid_q, err_q;
    logic [2*n-1:0] prod;
    logic [n-1:0]   red_rem;
    logic           red_done;

    always_comb begin
        prod = '0;
        case (state_q)
            PRE:     prod = {{n{1'b0}}, c_q};
            SQ:      prod = (2*n)'(acc_q) * (2*n)'(acc_q);
            ML:      prod = (2*n)'(acc_q) * (2*n)'(c_q);
            default: prod = '0;
        endcase
    end

    mod_reduce_seq #(.n(n)) u_red (
        .clk   (clk),
        .reset (reset),
        .start (mul_q),
        .prod  (prod),
        .N     (n_q),
        .rem   (red_rem),
        .done  (red_done)
    );

    // NEXT is folded into the last cycle of SQ/ML so the bit decision costs no extra cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            c_q         <= '0;
            d_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            mul_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        c_q        <= CIPHER;
                        d_q        <= PRIV_KEY;
                        n_q        <= N;
                        acc_q      <= n'(1);
                        i_q        <= IW'(n - 1);
                        in_ready_q <= 1'b0;
                        if (N < n'(2)) begin
                            state_q  <= DONE;
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state_q <= PRE;
                            mul_q   <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    mul_q <= 1'b0;
                    if (red_done) begin
                        c_q <= red_rem;
`ifdef RSA_EARLY_SKIP_EN
                        if (d_q == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= acc_q;
                        end else begin
                            i_q     <= IW'(msb_idx(32'(d_q)));
                            state_q <= SQ;
                            mul_q   <= 1'b1;
                        end
`else
                        state_q <= SQ;
                        mul_q   <= 1'b1;
`endif
                    end
                end
                SQ: begin
                    mul_q <= 1'b0;
                    if (red_done) begin
                        acc_q <= red_rem;
                        if (d_q[i_q]) begin
                            state_q <= ML;
                            mul_q   <= 1'b1;
                        end else if (i_q == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= red_rem;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= SQ;
                            mul_q   <= 1'b1;
                        end
                    end
                end
                ML: begin
                    mul_q <= 1'b0;
                    if (red_done) begin
                        acc_q <= red_rem;
                        if (i_q == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= red_rem;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= SQ;
                            mul_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The error path arrives with out_valid low and raises it one cycle later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign RESULT    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Self-checking bench for rsa_decrypt_engine: scoreboard of modexp results, error flag and latency.
module tb_rsa_decrypt_engine;

    typedef struct {
        logic [5:0] res;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] CIPHER = '0;
    logic [5:0] PRIV_KEY = '0;
    logic [5:0] N = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] RESULT;
    logic       err;

    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    rsa_decrypt_engine #(.n(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .CIPHER    (CIPHER),
        .PRIV_KEY  (PRIV_KEY),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULT    (RESULT),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int c, input int d, input int nn);
        exp_t e;
        int r, b, msb;
        if (nn < 2) begin
            e.res = 6'd0;
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        r = 1;
        b = c % nn;
        for (int k = 5; k >= 0; k--) begin
            r = (r * r) % nn;
            if (((d >> k) & 1) == 1) r = (r * b) % nn;
        end
        e.res = 6'(r);
        e.err = 1'b0;
`ifdef RSA_EARLY_SKIP_EN
        msb = 0;
        for (int k = 0; k < 6; k++) if (((d >> k) & 1) == 1) msb = k;
        e.lat = (d == 0) ? 13 : (1 + msb + 1 + $countones(d)) * 13;
`else
        msb = 0;
        e.lat = (1 + 6 + $countones(d)) * 13 + msb;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input int d, input int nn, output bit ok);
        int g;
        g = 0;
        while (!in_ready && g < 3000) begin
            step();
            g++;
        end
        ok = in_ready;
        CIPHER   = 6'(c);
        PRIV_KEY = 6'(d);
        N        = 6'(nn);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < 3000) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 4;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (RESULT !== 6'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", RESULT); end
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_modexp();
        int tc[4] = '{31, 40, 10, 20};
        int td[4] = '{7, 1, 5, 0};
        int tn[4] = '{33, 33, 33, 33};
        int lat;
        bit ok_in, ok_out;
        exp_t e;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            sb.push_back(model(tc[v], td[v], tn[v]));
            send(tc[v], td[v], tn[v], ok_in);
            wait_out(lat, ok_out);
            e = sb.pop_front();
            checks += 3;
            if (!ok_in || !ok_out) begin
                fails++;
                $display("FAIL modexp_timeout vec %0d: got no handshake expected completion", v);
            end
            if (RESULT !== e.res) begin fails++; $display("FAIL modexp_result vec %0d: got %0d expected %0d", v, RESULT, e.res); end
            if (err !== e.err) begin fails++; $display("FAIL modexp_err vec %0d: got %b expected %b", v, err, e.err); end
            if (lat != e.lat) begin fails++; $display("FAIL modexp_latency vec %0d: got %0d expected %0d", v, lat, e.lat); end
            step();
        end
    endtask

    task automatic test_error();
        int tn[2] = '{1, 0};
        int lat;
        bit ok_in, ok_out;
        exp_t e;
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            sb.push_back(model(5, 3, tn[v]));
            send(5, 3, tn[v], ok_in);
            wait_out(lat, ok_out);
            e = sb.pop_front();
            checks += 3;
            if (!ok_in || !ok_out) begin
                fails++;
                $display("FAIL error_timeout N=%0d: got no handshake expected completion", tn[v]);
            end
            if (RESULT !== e.res) begin fails++; $display("FAIL error_result N=%0d: got %0d expected %0d", tn[v], RESULT, e.res); end
            if (err !== e.err) begin fails++; $display("FAIL error_flag N=%0d: got %b expected %b", tn[v], err, e.err); end
            if (lat != e.lat) begin fails++; $display("FAIL error_latency N=%0d: got %0d expected %0d", tn[v], lat, e.lat); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok_in, ok_out;
        exp_t e;
        out_ready = 1'b0;
        sb.push_back(model(31, 7, 33));
        send(31, 7, 33, ok_in);
        wait_out(lat, ok_out);
        e = sb.pop_front();
        checks++;
        if (!ok_out || RESULT !== e.res) begin
            fails++;
            $display("FAIL bp_result: got %0d expected %0d", RESULT, e.res);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks += 3;
            if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cycle %0d: got %b expected 1", k, out_valid); end
            if (RESULT !== e.res || err !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_result cycle %0d: got %0d/%b expected %0d/0", k, RESULT, err, e.res);
            end
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", k, in_ready); end
        end
        out_ready = 1'b1;
        step();
        checks += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok_in, ok_out;
        exp_t e;
        out_ready = 1'b1;
        send(31, 7, 33, ok_in);
        repeat (40) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        sb.push_back(model(4, 3, 33));
        send(4, 3, 33, ok_in);
        wait_out(lat, ok_out);
        e = sb.pop_front();
        checks += 2;
        if (!ok_out || RESULT !== e.res) begin fails++; $display("FAIL midreset_result: got %0d expected %0d", RESULT, e.res); end
        if (lat != e.lat) begin fails++; $display("FAIL midreset_latency: got %0d expected %0d", lat, e.lat); end
        step();
    endtask

    task automatic test_back_to_back();
        int rc[3] = '{10, 4, 31};
        int rd[3] = '{5, 3, 7};
        int got, pulses, cyc;
        exp_t e;
        out_ready = 1'b1;
        got = 0;
        pulses = 0;
        cyc = 0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    bit acc;
                    int g;
                    sb.push_back(model(rc[k], rd[k], 33));
                    CIPHER   = 6'(rc[k]);
                    PRIV_KEY = 6'(rd[k]);
                    N        = 6'd33;
                    in_valid = 1'b1;
                    g = 0;
                    acc = 1'b0;
                    while (!acc && g < 3000) begin
                        acc = in_ready;
                        step();
                        g++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                while (got < 3 && cyc < 6000) begin
                    if (in_ready) pulses++;
                    if (out_valid) begin
                        e = sb.pop_front();
                        checks++;
                        if (RESULT !== e.res || err !== e.err) begin
                            fails++;
                            $display("FAIL b2b_result #%0d: got %0d/%b expected %0d/%b", got, RESULT, err, e.res, e.err);
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
            end
        join
        checks += 2;
        if (got != 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", got); end
        if (pulses != 3) begin fails++; $display("FAIL b2b_in_ready_pulses: got %0d expected 3", pulses); end
        sb.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_modexp();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt_engine.md
Name: rsa_decrypt_engine

Overview:
- Decrypt-side counterpart of the RSA encrypt datapath.
- Accepts a ciphertext C, private exponent D and modulus N over a valid/ready handshake, and computes M = C^D mod N.
- Uses left-to-right square-and-multiply, with a sequential shift-subtract modular reducer.
- Returns M over a second valid/ready handshake. Sits between the key/ciphertext source and the plaintext consumer.

Parameters:
- n, 6, operand width in bits (C, D, N, M).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  C/D/N presented
- in_ready  out  1  engine idle, can accept
- CIPHER  in  n  ciphertext C
- PRIV_KEY  in  n  private exponent D
- N  in  n  modulus
- out_valid  out  1  RESULT valid
- out_ready  in  1  consumer accepts RESULT
- RESULT  out  n  plaintext M
- err  out  1  N < 2 detected; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
  - On reset: state=IDLE, in_ready=1, out_valid=0, RESULT=0, err=0, internal registers 0.
  - Reset mid-operation aborts the computation. No partial result is emitted.
- Input handshake:
  - Accept occurs on a clk edge with in_valid && in_ready.
  - On accept, latch C, D, N; set acc=1 and bit index i=n-1.
  - in_ready=1 only in IDLE. It drops on the cycle after accept.
- Operation (op) definition: one op = 1 MUL cycle + 2n RED cycles = 2n+1 cycles.
  - MUL cycle: prod = a*b, 2n bits wide.
  - RED cycles: restoring reduction, MSB first, one bit per cycle. rem = {rem,bit}; if rem >= N then rem = rem - N.
  - rem register is n+1 bits. The final rem is < N.
- States:
  - IDLE: on accept, go to PRE if N>=2; otherwise go to DONE with err=1.
  - PRE: one op with prod = C zero-extended, i.e. C' = C mod N. Then go to SQ.
  - SQ: one op, acc = acc*acc mod N. Then go to ML if D[i]=1; otherwise to NEXT.
  - ML: one op, acc = acc*C' mod N. Then go to NEXT.
  - NEXT: zero-cycle decision. If i==0, go to DONE; else i = i-1 and go to SQ.
  - DONE: out_valid=1, RESULT=acc (0 if err). Hold until out_ready, then go to IDLE with out_valid=0 and err=0.
- Latency: out_valid rises (1 + n + popcount(D))*(2n+1) cycles after the accept edge.
- Error path: when N<2, out_valid rises 1 cycle after accept, with err=1 and RESULT=0.
- D=0: acc stays 1. Because N>=2, RESULT=1.
- C>=N: handled by the PRE reduction.
- Backpressure: RESULT and err are stable while out_valid && !out_ready. in_valid is ignored unless in IDLE.
- Simultaneous out handshake and new in_valid: the new operand is not accepted that cycle. It is accepted the following cycle (in IDLE).

Optional Feature:
- Macro: RSA_EARLY_SKIP_EN.
- Defined:
  - On leaving PRE, i starts at the index of the MSB set in D.
  - When D=0, go directly from PRE to DONE.
  - Latency = (1 + (msb(D)+1) + popcount(D))*(2n+1); (2n+1) when D=0.
- Undefined: fixed n squarings, with latency as given in Behaviour. Results are identical in both configurations.

Decomposition:
- rsa_pkg: state enum {IDLE, PRE, SQ, ML, NEXT, DONE}; function for op length (2n+1); reduction counter width $clog2(2n+1).
- Sub-module mod_reduce_seq:
  - Inputs: start, prod[2n-1:0], N.
  - Outputs: rem[n-1:0], done.
  - Takes 2n cycles; done pulses 1 cycle.
  - Reused by the PRE, SQ and ML states.

Test Plan:
- n=6: C=31, D=7, N=33 -> RESULT=4, err=0.
  - Without the macro, out_valid at cycle 130 after accept.
  - With the macro, out_valid at cycle 91.
- C=40, D=1, N=33 -> RESULT=7 (PRE reduction). C=10, D=5, N=33 -> RESULT=10.
- D=0, C=20, N=33 -> RESULT=1. N=1 -> err=1, RESULT=0, out_valid 1 cycle after accept. N=0 -> same.
- Backpressure: C=31, D=7, N=33 with out_ready held low 5 cycles after out_valid.
  - RESULT=4 is held stable.
  - in_ready=0 until the cycle after the out handshake.
- Reset asserted 40 cycles into C=31, D=7, N=33 -> next cycle out_valid=0, in_ready=1. A new request C=4, D=3, N=33 -> RESULT=31.
- Back-to-back: in_valid held high with 3 queued requests and out_ready=1 -> each result correct, in_ready pulses once per result.
